// File: rtl/acc_pkg.sv
// Shared opcode set and width helpers for
// the program-cache accumulator.
package acc_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_ACC    = 3'd1,
    OP_MAC    = 3'd2,
    OP_SUB    = 3'd3,
    OP_POPCNT = 3'd4,
    OP_REV    = 3'd5,
    OP_LOOP   = 3'd6,
    OP_HALT   = 3'd7
  } op_e;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_VAL_W  = 4;
  localparam int DEF_DEPTH  = 32;

  function automatic int pc_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int wide_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational datapath for one instruction:
// wide arithmetic, overflow, wrap or clamp.
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int VAL_W    = 4,
  parameter int SATURATE = 0
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  input  logic [VAL_W-1:0]  v,
  output logic [DATA_W-1:0] next_p0,
  output logic              ovf
);

  localparam int WIDE_W = wide_width(DATA_W);

  logic [WIDE_W-1:0] a, b, vw, wide, max_w;
  logic [DATA_W-1:0] pop, rev;
  logic              under, big;

  assign a     = WIDE_W'(p0);
  assign b     = WIDE_W'(p1);
  assign vw    = WIDE_W'(v);
  assign max_w = WIDE_W'({DATA_W{1'b1}});

  // bit count and bit reversal of p0
  always_comb begin
    pop = '0;
    rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop    = pop + DATA_W'(p0[i]);
      rev[i] = p0[DATA_W-1-i];
    end
  end

  // opcode select, overflow detect, wrap/clamp
  always_comb begin
    wide    = a;
    under   = 1'b0;
    big     = 1'b0;
    next_p0 = p0;
    unique case (op)
      OP_ADD:    wide = a + vw;
      OP_ACC:    wide = a + b + vw;
      OP_MAC:    wide = a * b + vw;
      OP_SUB: begin
        wide  = a - vw;
        under = vw > a;
      end
      OP_POPCNT: wide = WIDE_W'(pop);
      OP_REV:    wide = WIDE_W'(rev);
      default:   wide = a;
    endcase
    big     = !under && (wide > max_w);
    next_p0 = wide[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (under)    next_p0 = '0;
      else if (big) next_p0 = '1;
    end
  end

  assign ovf = under | big;

endmodule

// File: rtl/prog_accumulator.sv
// Program-cache accumulator: loads (op, value)
// pairs, then runs them in a loop on p0/p1.
module prog_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int VAL_W    = DEF_VAL_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic                     cache_clr,
  input  logic [2:0]               opCode,
  input  logic [VAL_W-1:0]         value,
  output logic [DATA_W-1:0]        result,
  output logic                     result_valid,
  output logic                     cacheFull,
  output logic                     invalidOp,
  output logic                     overflow,
  output logic                     halted,
  output logic [$clog2(DEPTH)-1:0] pc_out
);

  localparam int PC_W  = pc_width(DEPTH);
  localparam int CNT_W = PC_W + 1;

  logic [2:0]       op_mem  [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];

  logic [CNT_W-1:0]  count;
  logic [PC_W-1:0]   pc, loop_start;
  logic [PC_W-1:0]   ls_eff, pc_next;
  logic [DATA_W-1:0] p0, p1, alu_p0;
  logic [VAL_W-1:0]  cur_val;
  op_e               cur_op;
  logic              alu_ovf, wrap;
  logic              load_req, loop_bad;
  logic              load_ok, run_go;

  assign cur_op  = op_e'(op_mem[pc]);
  assign cur_val = val_mem[pc];

  assign load_req = !cache_clr && !mode && in_valid;
  assign loop_bad = (op_e'(opCode) == OP_LOOP) &&
                    (32'(value) >= 32'(DEPTH));
  assign load_ok  = load_req && !loop_bad &&
                    (count < CNT_W'(DEPTH));
  assign run_go   = !cache_clr && mode &&
                    !halted && (count != '0);

  assign cacheFull = count == CNT_W'(DEPTH);
  assign pc_out    = pc;

  // a LOOP at the wrap point redirects this edge
  assign ls_eff = (cur_op == OP_LOOP) ?
                  PC_W'(cur_val) : loop_start;
  assign wrap   = (CNT_W'(pc) + 1'b1) >= count;

  // next PC: hold on HALT, step, or wrap
  always_comb begin
    pc_next = pc + 1'b1;
    if (cur_op == OP_HALT)
      pc_next = pc;
    else if (wrap)
      pc_next = (CNT_W'(ls_eff) >= count) ?
                '0 : ls_eff;
  end

  acc_alu #(
    .DATA_W   (DATA_W),
    .VAL_W    (VAL_W),
    .SATURATE (SATURATE)
  ) u_alu (
    .op      (cur_op),
    .p0      (p0),
    .p1      (p1),
    .v       (cur_val),
    .next_p0 (alu_p0),
    .ovf     (alu_ovf)
  );

  // instruction cache write port
  always_ff @(posedge clk) begin
    if (load_ok) begin
      op_mem[count[PC_W-1:0]]  <= opCode;
      val_mem[count[PC_W-1:0]] <= value;
    end
  end

  // control state, accumulators and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      pc           <= '0;
      loop_start   <= '0;
      halted       <= 1'b0;
      p0           <= '0;
      p1           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      invalidOp    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      invalidOp    <= 1'b0;
      if (cache_clr) begin
        count      <= '0;
        pc         <= '0;
        loop_start <= '0;
        halted     <= 1'b0;
      end else if (!mode) begin
        pc     <= '0;
        halted <= 1'b0;
        if (in_valid) begin
          if (load_ok) count     <= count + 1'b1;
          else         invalidOp <= 1'b1;
        end
      end else if (run_go) begin
        p1           <= p0;
        p0           <= alu_p0;
        result       <= alu_p0;
        result_valid <= 1'b1;
        overflow     <= alu_ovf;
        pc           <= pc_next;
        if (cur_op == OP_LOOP) loop_start <= ls_eff;
        if (cur_op == OP_HALT) halted     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/prog_accumulator.md
Name: prog_accumulator

Overview:
- Parametrised program-cache accumulator and next generation of the lab4 accumulator.
- In load mode it captures (opcode, value) pairs into an instruction cache of DEPTH entries.
- In run mode it executes the cache one instruction per clock on a DATA_W-bit accumulator pair (p0 = current, p1 = previous p0), looping from a programmable loop start.
- New over the previous generation: load handshake, SUB and HALT opcodes, saturating option, cache clear, halt status, PC visibility.

Parameters:
- DATA_W, 10: accumulator/result width.
- VAL_W, 4: immediate value width.
- DEPTH, 32: instruction cache entries (power of two, >= 2).
- SATURATE, 0: 0 = wrap on overflow, 1 = clamp to max (or 0 on SUB underflow).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = load, 1 = run.
- in_valid  in  1  load strobe, sampled only when mode=0.
- cache_clr  in  1  synchronous cache clear, any mode; has priority over load and run.
- opCode  in  3  instruction opcode.
- value  in  VAL_W  instruction immediate.
- result  out  DATA_W  registered p0 after each executed instruction.
- result_valid  out  1  one-cycle pulse per executed instruction.
- cacheFull  out  1  count == DEPTH.
- invalidOp  out  1  one-cycle pulse on a rejected load.
- overflow  out  1  flag from the last executed instruction.
- halted  out  1  HALT executed; run is frozen.
- pc_out  out  clog2(DEPTH)  current PC.

Behaviour:
- Reset (reset=0, async): every output is 0; p0, p1, PC, count, loop_start and halted are 0; cache contents are don't-care.
- Opcodes: 0 ADD p0+v; 1 ACC p0+p1+v; 2 MAC p0*p1+v; 3 SUB p0-v; 4 POPCNT(p0, all DATA_W bits); 5 REV (bit-reverse all DATA_W bits); 6 LOOP (loop_start=v); 7 HALT.
- Load, one cycle per accepted entry (mode=0 & in_valid):
  - LOOP with v >= DEPTH -> invalidOp pulses, no write.
  - Otherwise, if count < DEPTH -> write cache[count], count++.
  - Otherwise (cache full) -> entry dropped, invalidOp pulses, cacheFull stays 1.
- cacheFull is combinational from count.
- Run (mode=1, !halted, count>0): one instruction per clk at cache[PC]. On that edge:
  - p1 <= old p0; p0 <= new value.
  - result <= new p0; result_valid <= 1; overflow updated.
  - LOOP and HALT leave p0 unchanged but still advance p1 and pulse result_valid.
- Arithmetic:
  - Computed in 2*DATA_W+1 bits.
  - overflow=1 if the true result > 2^DATA_W-1, or SUB underflows.
  - SATURATE=0: keep the low DATA_W bits.
  - SATURATE=1: clamp to all-ones, or to 0 on underflow.
  - POPCNT and REV never overflow.
- PC update: PC <= PC+1; if PC+1 >= count then PC <= loop_start.
  - The LOOP target takes effect on the same edge if that instruction is the wrap point.
  - A loop_start >= count at wrap time -> PC <= 0.
- HALT: sets halted=1 and PC does not advance. While halted, run cycles change nothing and result_valid=0.
- Run with count==0: no state change, result_valid=0.
- Any mode=0 cycle: clears halted, PC <= 0, result_valid=0; p0, p1 and result are retained.
- Mode 1->0->1: execution restarts at PC=0 with the accumulator history retained.
- cache_clr: count, PC, loop_start, halted <= 0; p0, p1, result are retained; the same-cycle load is ignored.
- Reset mid-run: immediate clear per the reset rule; the next run without reload does nothing (count=0).

Decomposition:
- Package acc_pkg:
  - opcode enum (OP_ADD..OP_HALT).
  - localparam helpers: PC_W=clog2(DEPTH), WIDE_W=2*DATA_W+1.
- Sub-module acc_alu (combinational): inputs op, p0, p1, v; outputs next_p0, ovf; SATURATE passed through.
- Top holds the cache arrays, count, PC, loop_start, halted and the output registers.

Test Plan:
- Load ADD 5, ADD 3, run 2 cycles -> result 5 then 8; result_valid pulses twice; overflow 0; pc_out 1, 0.
- Defaults: load ADD 15, MAC 15, run -> 15, then 15*0+15=15; further cycles loop from 0: ADD -> 30; MAC 30*15+15=465; ADD 480; MAC 480*465+15 -> overflow=1, result = low 10 bits (SATURATE=0) or 1023 (SATURATE=1).
- Load 33 entries -> cacheFull=1 after the 32nd; the 33rd pulses invalidOp and count stays 32; cache_clr -> cacheFull=0, pc_out=0.
- Program SUB 1 from p0=0 -> overflow=1, result 1023 (wrap) or 0 (saturate); then REV of 1 -> 512; POPCNT of 1023 -> 10.
- Program ADD 1, LOOP 1, ADD 2, HALT:
  - results 1, 1, 3, 3; halted=1; further run cycles give no result_valid.
  - A mode=0 cycle then mode=1 -> restart at PC 0 with p0=3 -> result 4.
- Assert reset low mid-run between edges -> all outputs 0 asynchronously; after release, run with no reload -> result_valid stays 0.
